oflow_conflict_resolve: RTL and testbench
=========================================

// Module: oflow_conflict_resolve
// PURPOSE
//  Resolves ID conflicts in the score board after registration, so each current-frame row ends with a unique ID.
//  Sequentially scans row pairs through the score board's combinational read port; the worse-scoring row of a duplicate pair loses.
//  The losing row falls back to its 2nd-choice ID (pointer 0->1). A row already on its 2nd choice gets a fresh ID instead.
//  Sits directly downstream of oflow_score_board (consumes score_to_cr/id_to_cr, drives its CR write port); controlled by the core FSM.
// PARAMETERS
//  MAX_ROWS  `MAX_ROWS_IN_SCORE_BOARD  rows scanned; ROW_LEN = $clog2(MAX_ROWS)
//  ID_LEN    `ID_LEN                   object ID width
//  SCORE_LEN `SCORE_LEN                score width; lower score = better match
//  MAX_PASSES 2*MAX_ROWS+1             watchdog on full scan passes
// PORTS
//  clk                   in   1          clock, rising edge
//  reset_N               in   1          async active-low reset
//  ready_new_frame       in   1          sync clear of all state (same cycle as score board clear)
//  start_cr              in   1          1-cycle pulse; accepted only in IDLE
//  num_of_rows           in   ROW_LEN+1  valid rows 0..MAX_ROWS, sampled at start_cr
//  id_base               in   ID_LEN     first free ID, sampled at start_cr
//  score_to_cr           in   SCORE_LEN  selected score of row_sel_from_cr (same-cycle)
//  id_to_cr              in   ID_LEN     selected ID of row_sel_from_cr (same-cycle)
//  row_sel_from_cr       out  ROW_LEN    read row select
//  row_to_change         out  ROW_LEN    write row select
//  write_to_pointer      out  1          write pointer strobe
//  data_from_cr_pointer  out  1          pointer value
//  write_to_id           out  1          write new-ID strobe (score board stores it in the upper/slot-0 ID)
//  data_from_cr_id       out  ID_LEN     fresh ID value
//  next_free_id          out  ID_LEN     first unused ID after resolution; valid when done_cr=1
//  done_cr               out  1          1-cycle pulse, resolution finished
//  err_cr                out  1          watchdog tripped; held until next start_cr/ready_new_frame
// BEHAVIOUR
//  Reset/ready_new_frame: FSM=IDLE.
//   All outputs 0 except next_free_id, which holds its last value (0 after reset).
//   Shadow pointer bitmap, pass count and changed flag are cleared.
//  States:
//   IDLE   - on start_cr: latch num_of_rows and id_base into free_id; clear shadow_ptr[], changed and passes; i=1.
//            If num_of_rows<=1 go to DONE, else go to LOAD_I.
//   LOAD_I - row_sel_from_cr=i; capture id_i/score_i; j=0; go to CMP.
//   CMP    - row_sel_from_cr=j; compares id_to_cr against id_i.
//            On equal IDs: loser=i if score_i>=score_j (tie: higher index i loses), else loser=j; go to WRITE.
//            Otherwise j++; when j reaches i-1, ADVANCE_I.
//   WRITE  - one cycle, row_to_change=loser:
//            * shadow_ptr[loser]==0: write_to_pointer=1, data_from_cr_pointer=1, shadow_ptr[loser]<=1.
//            * shadow_ptr[loser]==1: write_to_id=1, data_from_cr_id=free_id,
//              plus write_to_pointer=1, data_from_cr_pointer=0 in the same cycle; shadow_ptr[loser]<=0; free_id++.
//            In both cases changed<=1, then ADVANCE_I.
//   ADVANCE_I (transition action, not a state):
//            - i<num_of_rows-1: i++, go to LOAD_I.
//            - else, end of pass: passes++. If changed: clear it, i=1, go to LOAD_I. Otherwise go to DONE.
//            - passes==MAX_PASSES: err_cr<=1, go to DONE.
//   DONE   - done_cr=1 for one cycle; next_free_id=free_id; go to IDLE.
//  Timing:
//   - Score board read is combinational, so one compare per cycle; a WRITE is visible on the read port the next cycle.
//   - Latency without conflicts is sum over i=1..N-1 of (1+i) cycles plus 2 (IDLE->DONE->IDLE).
//  Write strobes are 1-cycle pulses and are never asserted outside WRITE.
//  Termination: a fresh ID never conflicts, so each row is written at most twice; the watchdog exists only for protocol faults.
//  free_id wraps modulo 2^ID_LEN with no check; the core guarantees ID headroom.
//  start_cr outside IDLE is ignored. ready_new_frame mid-scan aborts with no done_cr.
//  No arithmetic on scores; unsigned compare only.
// STRUCTURE
//  oflow_core_define.sv holds ID_LEN, SCORE_LEN, MAX_ROWS_IN_SCORE_BOARD, ROW_LEN.
//  The shared package gains cr_state_t (IDLE, LOAD_I, CMP, WRITE, DONE).
//  Single module; no sub-module. Shadow pointer kept as a MAX_ROWS-bit vector.
//  Next-state logic is combinational; registers are async-reset.
// TESTING
//  Bench pairs the DUT with oflow_score_board, preloaded via its start_score_board port.
//  1 No conflict: 3 rows, ids {5,7,9} -> done_cr after 7 cycles; no write strobes; id_out={5,7,9}.
//  2 Simple conflict: rows 0/1 top ids 5/5, scores 10/20, 2nd ids 3/8
//    -> one WRITE row 1, pointer=1; id_out={5,8}; next_free_id=id_base.
//  3 Tie plus cascade: rows {id 4 sc 10 / 2nd 6}, {id 4 sc 10 / 2nd 6}
//    -> row 1 moves to 6 (no conflict); then rows {4/6, 6/9 score 5} chain
//    -> verify row-0 loss path and a second pass; all final ids unique.
//  4 Fresh ID: row 1 already on 2nd choice conflicts again, id_base=100
//    -> same-cycle write_to_id=1 (100) and pointer=0; next_free_id=101.
//  5 Abort: ready_new_frame during CMP -> FSM IDLE next cycle, no done_cr; new start_cr runs clean.
//  6 Edges: num_of_rows=0 and 1 -> done_cr 2 cycles after start_cr.
//    start_cr while busy -> ignored.
//    Async reset mid-WRITE -> all strobes 0 immediately.

Source files
------------

// File: rtl/oflow_conflict_resolve_pkg.sv
// Shared types and sizing for the conflict-resolve stage of the optical-flow core.
package oflow_conflict_resolve_pkg;

  localparam int CR_MAX_ROWS  = 8;
  localparam int CR_ID_LEN    = 8;
  localparam int CR_SCORE_LEN = 8;
  localparam int CR_ROW_LEN   = $clog2(CR_MAX_ROWS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_I,
    CMP,
    WRITE,
    DONE
  } cr_state_t;

endpackage

// File: rtl/oflow_conflict_resolve.sv
// Conflict resolver: scans score-board row pairs (i, j<i) through the
// combinational read port and, on a duplicate ID, demotes the worse-scoring
// row to its 2nd choice, or hands it a fresh ID if it was already demoted.
// Passes repeat until one full pass makes no change.
module oflow_conflict_resolve
  import oflow_conflict_resolve_pkg::*;
#(
  parameter int MAX_ROWS  = CR_MAX_ROWS,
  parameter int ID_LEN    = CR_ID_LEN,
  parameter int SCORE_LEN = CR_SCORE_LEN,
  localparam int ROW_LEN  = $clog2(MAX_ROWS)
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 ready_new_frame,
  input  logic                 start_cr,
  input  logic [ROW_LEN:0]     num_of_rows,
  input  logic [ID_LEN-1:0]    id_base,
  input  logic [SCORE_LEN-1:0] score_to_cr,
  input  logic [ID_LEN-1:0]    id_to_cr,
  output logic [ROW_LEN-1:0]   row_sel_from_cr,
  output logic [ROW_LEN-1:0]   row_to_change,
  output logic                 write_to_pointer,
  output logic                 data_from_cr_pointer,
  output logic                 write_to_id,
  output logic [ID_LEN-1:0]    data_from_cr_id,
  output logic [ID_LEN-1:0]    next_free_id,
  output logic                 done_cr,
  output logic                 err_cr
);

  localparam int MAX_PASSES = 2 * MAX_ROWS + 1;
  localparam int PASS_W     = $clog2(MAX_PASSES + 1);
  localparam int RW1        = ROW_LEN + 1;

  cr_state_t            state, state_nxt;
  logic [ROW_LEN-1:0]   i_row, i_row_nxt;
  logic [ROW_LEN-1:0]   j_row, j_row_nxt;
  logic [ROW_LEN:0]     num_rows, num_rows_nxt;
  logic [ID_LEN-1:0]    id_i, id_i_nxt;
  logic [SCORE_LEN-1:0] score_i, score_i_nxt;
  logic [MAX_ROWS-1:0]  shadow_ptr, shadow_ptr_nxt;
  logic                 changed, changed_nxt;
  logic [PASS_W-1:0]    passes, passes_nxt, passes_inc;
  logic [ID_LEN-1:0]    free_id, free_id_nxt;

  logic                 wr_ptr_nxt, ptr_data_nxt, wr_id_nxt, done_nxt, err_nxt;
  logic [ID_LEN-1:0]    id_data_nxt, nfid_nxt;
  logic [ROW_LEN-1:0]   row_chg_nxt;
  logic                 advance;
  logic [ROW_LEN-1:0]   loser;

  // Read port follows row i while loading it, row j while comparing.
  assign row_sel_from_cr = (state == LOAD_I) ? i_row :
                           (state == CMP)    ? j_row : '0;
  assign passes_inc      = passes + PASS_W'(1);
  // Worse (higher or equal) score of row i loses; ties go against the later row.
  assign loser           = (score_i >= score_to_cr) ? i_row : j_row;

  // Next-state and next-output computation for the scan FSM.
  always_comb begin
    state_nxt      = state;
    i_row_nxt      = i_row;
    j_row_nxt      = j_row;
    num_rows_nxt   = num_rows;
    id_i_nxt       = id_i;
    score_i_nxt    = score_i;
    shadow_ptr_nxt = shadow_ptr;
    changed_nxt    = changed;
    passes_nxt     = passes;
    free_id_nxt    = free_id;
    wr_ptr_nxt     = 1'b0;
    ptr_data_nxt   = 1'b0;
    wr_id_nxt      = 1'b0;
    id_data_nxt    = '0;
    row_chg_nxt    = '0;
    done_nxt       = 1'b0;
    err_nxt        = err_cr;
    nfid_nxt       = next_free_id;
    advance        = 1'b0;

    case (state)
      IDLE: begin
        if (start_cr) begin
          num_rows_nxt   = num_of_rows;
          free_id_nxt    = id_base;
          shadow_ptr_nxt = '0;
          changed_nxt    = 1'b0;
          passes_nxt     = '0;
          i_row_nxt      = ROW_LEN'(1);
          err_nxt        = 1'b0;
          state_nxt      = (num_of_rows <= RW1'(1)) ? DONE : LOAD_I;
        end
      end
      LOAD_I: begin
        id_i_nxt    = id_to_cr;
        score_i_nxt = score_to_cr;
        j_row_nxt   = '0;
        state_nxt   = CMP;
      end
      CMP: begin
        if (id_to_cr == id_i) begin
          // Strobes are registered so they are live exactly during WRITE.
          row_chg_nxt = loser;
          wr_ptr_nxt  = 1'b1;
          state_nxt   = WRITE;
          if (!shadow_ptr[loser]) begin
            ptr_data_nxt = 1'b1;
          end else begin
            wr_id_nxt    = 1'b1;
            id_data_nxt  = free_id;
            ptr_data_nxt = 1'b0;
          end
        end else if (j_row == i_row - ROW_LEN'(1)) begin
          advance = 1'b1;
        end else begin
          j_row_nxt = j_row + ROW_LEN'(1);
        end
      end
      WRITE: begin
        if (shadow_ptr[row_to_change]) begin
          shadow_ptr_nxt[row_to_change] = 1'b0;
          free_id_nxt                   = free_id + ID_LEN'(1);
        end else begin
          shadow_ptr_nxt[row_to_change] = 1'b1;
        end
        changed_nxt = 1'b1;
        advance     = 1'b1;
      end
      DONE: begin
        done_nxt  = 1'b1;
        nfid_nxt  = free_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (advance) begin
      if (RW1'(i_row) + RW1'(1) < num_rows) begin
        i_row_nxt = i_row + ROW_LEN'(1);
        state_nxt = LOAD_I;
      end else begin
        passes_nxt = passes_inc;
        if (!changed_nxt) begin
          state_nxt = DONE;
        end else if (int'(passes_inc) >= MAX_PASSES) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          changed_nxt = 1'b0;
          i_row_nxt   = ROW_LEN'(1);
          state_nxt   = LOAD_I;
        end
      end
    end

    // New frame wipes the scan; the last reported free ID survives.
    if (ready_new_frame) begin
      state_nxt      = IDLE;
      shadow_ptr_nxt = '0;
      passes_nxt     = '0;
      changed_nxt    = 1'b0;
      wr_ptr_nxt     = 1'b0;
      ptr_data_nxt   = 1'b0;
      wr_id_nxt      = 1'b0;
      id_data_nxt    = '0;
      row_chg_nxt    = '0;
      done_nxt       = 1'b0;
      err_nxt        = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state                <= IDLE;
      i_row                <= '0;
      j_row                <= '0;
      num_rows             <= '0;
      id_i                 <= '0;
      score_i              <= '0;
      shadow_ptr           <= '0;
      changed              <= 1'b0;
      passes               <= '0;
      free_id              <= '0;
      write_to_pointer     <= 1'b0;
      data_from_cr_pointer <= 1'b0;
      write_to_id          <= 1'b0;
      data_from_cr_id      <= '0;
      row_to_change        <= '0;
      done_cr              <= 1'b0;
      err_cr               <= 1'b0;
      next_free_id         <= '0;
    end else begin
      state                <= state_nxt;
      i_row                <= i_row_nxt;
      j_row                <= j_row_nxt;
      num_rows             <= num_rows_nxt;
      id_i                 <= id_i_nxt;
      score_i              <= score_i_nxt;
      shadow_ptr           <= shadow_ptr_nxt;
      changed              <= changed_nxt;
      passes               <= passes_nxt;
      free_id              <= free_id_nxt;
      write_to_pointer     <= wr_ptr_nxt;
      data_from_cr_pointer <= ptr_data_nxt;
      write_to_id          <= wr_id_nxt;
      data_from_cr_id      <= id_data_nxt;
      row_to_change        <= row_chg_nxt;
      done_cr              <= done_nxt;
      err_cr               <= err_nxt;
      next_free_id         <= nfid_nxt;
    end
  end

endmodule

// File: tb/tb_oflow_conflict_resolve.sv
// Bench for oflow_conflict_resolve with a behavioural two-slot score board.
module tb_oflow_conflict_resolve;
  import oflow_conflict_resolve_pkg::*;

  localparam int MR   = CR_MAX_ROWS;
  localparam int IDW  = CR_ID_LEN;
  localparam int SCW  = CR_SCORE_LEN;
  localparam int RW   = $clog2(MR);
  localparam int MAXP = 2 * MR + 1;

  logic           clk = 1'b0;
  logic           reset_N, ready_new_frame, start_cr;
  logic [RW:0]    num_of_rows;
  logic [IDW-1:0] id_base;
  logic [SCW-1:0] score_to_cr;
  logic [IDW-1:0] id_to_cr;
  logic [RW-1:0]  row_sel_from_cr, row_to_change;
  logic           write_to_pointer, data_from_cr_pointer, write_to_id;
  logic [IDW-1:0] data_from_cr_id, next_free_id;
  logic           done_cr, err_cr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  oflow_conflict_resolve dut (
    .clk(clk), .reset_N(reset_N), .ready_new_frame(ready_new_frame), .start_cr(start_cr),
    .num_of_rows(num_of_rows), .id_base(id_base), .score_to_cr(score_to_cr), .id_to_cr(id_to_cr),
    .row_sel_from_cr(row_sel_from_cr), .row_to_change(row_to_change),
    .write_to_pointer(write_to_pointer), .data_from_cr_pointer(data_from_cr_pointer),
    .write_to_id(write_to_id), .data_from_cr_id(data_from_cr_id),
    .next_free_id(next_free_id), .done_cr(done_cr), .err_cr(err_cr)
  );

  // Score board model: slot 0 / slot 1 candidates, a pointer selects one.
  logic [IDW-1:0] sb_id0 [MR], sb_id1 [MR], ld_id0 [MR], ld_id1 [MR];
  logic [SCW-1:0] sb_sc0 [MR], sb_sc1 [MR], ld_sc0 [MR], ld_sc1 [MR];
  logic           sb_ptr [MR];
  logic           ld_en = 1'b0, sb_frozen = 1'b0;
  int             wr_cnt = 0, bad_cnt = 0;
  logic [RW-1:0]  last_wr_row = '0;
  logic [IDW-1:0] last_id_data = '0;
  logic           prev_strobe = 1'b0;

  always_comb begin
    id_to_cr    = sb_ptr[row_sel_from_cr] ? sb_id1[row_sel_from_cr] : sb_id0[row_sel_from_cr];
    score_to_cr = sb_ptr[row_sel_from_cr] ? sb_sc1[row_sel_from_cr] : sb_sc0[row_sel_from_cr];
  end

  always @(posedge clk) begin
    if (ld_en) begin
      for (int r = 0; r < MR; r++) begin
        sb_id0[r] <= ld_id0[r]; sb_id1[r] <= ld_id1[r];
        sb_sc0[r] <= ld_sc0[r]; sb_sc1[r] <= ld_sc1[r];
        sb_ptr[r] <= 1'b0;
      end
      wr_cnt <= 0; bad_cnt <= 0; prev_strobe <= 1'b0;
    end else begin
      prev_strobe <= write_to_pointer | write_to_id;
      if (write_to_pointer | write_to_id) begin
        wr_cnt      <= wr_cnt + (write_to_pointer ? 1 : 0);
        last_wr_row <= row_to_change;
        bad_cnt     <= bad_cnt + (prev_strobe ? 1 : 0)
                     + ((write_to_id && !(write_to_pointer && !data_from_cr_pointer)) ? 1 : 0);
        if (write_to_id) last_id_data <= data_from_cr_id;
        if (!sb_frozen) begin
          if (write_to_pointer) sb_ptr[row_to_change] <= data_from_cr_pointer;
          if (write_to_id)      sb_id0[row_to_change] <= data_from_cr_id;
        end
      end
    end
  end

  // Reference results.
  logic [IDW-1:0] exp_id [MR];
  logic [IDW-1:0] exp_nfid;
  int             exp_cyc, exp_wr;
  bit             exp_err;

  // Resolution as plain nested loops over passes and row pairs.
  task automatic model_run(input int n, input logic [IDW-1:0] base, input bit frozen);
    logic [IDW-1:0] id0 [MR], id1 [MR];
    logic [SCW-1:0] s0 [MR], s1 [MR];
    bit             p [MR], sh [MR];
    logic [IDW-1:0] fresh;
    int             passes, loser;
    bit             changed;
    for (int r = 0; r < MR; r++) begin
      id0[r] = ld_id0[r]; id1[r] = ld_id1[r]; s0[r] = ld_sc0[r]; s1[r] = ld_sc1[r];
      p[r] = 0; sh[r] = 0;
    end
    fresh = base; exp_cyc = 2; exp_wr = 0; exp_err = 0; passes = 0;
    if (n > 1) begin
      do begin
        changed = 0;
        for (int i = 1; i < n; i++) begin
          exp_cyc++;
          for (int j = 0; j < i; j++) begin
            exp_cyc++;
            if ((p[i] ? id1[i] : id0[i]) == (p[j] ? id1[j] : id0[j])) begin
              loser = ((p[i] ? s1[i] : s0[i]) >= (p[j] ? s1[j] : s0[j])) ? i : j;
              if (!sh[loser]) begin
                sh[loser] = 1;
                if (!frozen) p[loser] = 1;
              end else begin
                sh[loser] = 0;
                if (!frozen) begin id0[loser] = fresh; p[loser] = 0; end
                fresh = fresh + 1'b1;
              end
              exp_wr++; exp_cyc++; changed = 1;
              break;
            end
          end
        end
        passes++;
        if (changed && passes >= MAXP) begin exp_err = 1; changed = 0; end
      end while (changed);
    end
    for (int r = 0; r < MR; r++) exp_id[r] = p[r] ? id1[r] : id0[r];
    exp_nfid = fresh;
  endtask

  task automatic set_row(input int r, input int i0, input int c0, input int i1, input int c1);
    ld_id0[r] = IDW'(i0); ld_sc0[r] = SCW'(c0); ld_id1[r] = IDW'(i1); ld_sc1[r] = SCW'(c1);
  endtask

  task automatic load_sb();
    ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Pulse start_cr and count edges until done_cr; optional spurious start at cycle kick.
  task automatic do_run(input int n, input int base, input int kick, output int cyc, output bit to);
    num_of_rows = (RW+1)'(n); id_base = IDW'(base); start_cr = 1'b1;
    @(posedge clk); #1;
    start_cr = 1'b0; cyc = 1; to = 0;
    while (!done_cr) begin
      if (cyc >= 3000) begin to = 1; break; end
      start_cr = (cyc == kick);
      if (cyc == kick) begin num_of_rows = (RW+1)'(2); id_base = IDW'(77); end
      @(posedge clk); #1;
      start_cr = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_N = 1'b1; ready_new_frame = 0; start_cr = 0; num_of_rows = '0; id_base = '0;
    #2 reset_N = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({write_to_pointer, data_from_cr_pointer, write_to_id, done_cr, err_cr} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 00000",
        {write_to_pointer, data_from_cr_pointer, write_to_id, done_cr, err_cr});
    end
    checks++;
    if ({row_sel_from_cr, row_to_change, data_from_cr_id, next_free_id} !== '0) begin
      errors++; $display("FAIL reset_data: sel=%0d row=%0d id=%0d nfid=%0d expected all 0",
        row_sel_from_cr, row_to_change, data_from_cr_id, next_free_id);
    end
    @(negedge clk); reset_N = 1'b1;
  endtask

  task automatic test_no_conflict();
    int cyc; bit to;
    set_row(0, 5, 10, 1, 50); set_row(1, 7, 10, 1, 50); set_row(2, 9, 10, 1, 50);
    load_sb(); model_run(3, 40, 0);
    do_run(3, 40, 0, cyc, to);
    checks++; if (to || cyc !== 7) begin errors++; $display("FAIL noconf_latency: got %0d expected 7", cyc); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL noconf_writes: got %0d expected 0", wr_cnt); end
    checks++; if ({sb_id0[0], sb_id0[1], sb_id0[2]} !== {8'd5, 8'd7, 8'd9} || sb_ptr[1] !== 1'b0) begin
      errors++; $display("FAIL noconf_ids: got %0d,%0d,%0d expected 5,7,9", sb_id0[0], sb_id0[1], sb_id0[2]); end
    checks++; if (next_free_id !== exp_nfid) begin errors++; $display("FAIL noconf_nfid: got %0d expected %0d", next_free_id, exp_nfid); end
    @(posedge clk); #1;
    checks++; if (done_cr !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", done_cr); end
  endtask

  task automatic test_simple_conflict();
    int cyc; bit to;
    set_row(0, 5, 10, 3, 40); set_row(1, 5, 20, 8, 40);
    load_sb(); model_run(2, 60, 0);
    do_run(2, 60, 0, cyc, to);
    checks++; if (to || cyc !== exp_cyc) begin errors++; $display("FAIL simple_latency: got %0d expected %0d", cyc, exp_cyc); end
    checks++; if (wr_cnt !== 1 || last_wr_row !== 1) begin errors++; $display("FAIL simple_write: got %0d writes row %0d expected 1 row 1", wr_cnt, last_wr_row); end
    checks++; if (id_to_cr !== 5 || (sb_ptr[1] ? sb_id1[1] : sb_id0[1]) !== 8) begin
      errors++; $display("FAIL simple_ids: got row1 %0d expected 8", sb_ptr[1] ? sb_id1[1] : sb_id0[1]); end
    checks++; if (next_free_id !== 60) begin errors++; $display("FAIL simple_nfid: got %0d expected 60", next_free_id); end
  endtask

  task automatic test_cascade();
    int cyc; bit to; int bad;
    set_row(0, 4, 10, 6, 15); set_row(1, 4, 10, 6, 15);
    load_sb(); model_run(2, 30, 0);
    do_run(2, 30, 0, cyc, to);
    checks++; if (to || sb_ptr[1] !== 1'b1 || sb_ptr[0] !== 1'b0 || cyc !== exp_cyc) begin
      errors++; $display("FAIL tie_loss: ptr0=%0d ptr1=%0d cyc=%0d expected 0,1,%0d", sb_ptr[0], sb_ptr[1], cyc, exp_cyc); end
    set_row(0, 4, 10, 6, 15); set_row(1, 4, 5, 9, 20); set_row(2, 6, 3, 9, 30);
    load_sb(); model_run(3, 30, 0);
    do_run(3, 30, 0, cyc, to);
    bad = 0;
    for (int r = 0; r < 3; r++) if ((sb_ptr[r] ? sb_id1[r] : sb_id0[r]) !== exp_id[r]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL cascade_ids: got %0d,%0d,%0d expected %0d,%0d,%0d",
      sb_ptr[0] ? sb_id1[0] : sb_id0[0], sb_ptr[1] ? sb_id1[1] : sb_id0[1], sb_ptr[2] ? sb_id1[2] : sb_id0[2],
      exp_id[0], exp_id[1], exp_id[2]); end
    checks++; if (to || cyc !== exp_cyc || wr_cnt !== exp_wr || next_free_id !== exp_nfid) begin
      errors++; $display("FAIL cascade_run: cyc=%0d wr=%0d nfid=%0d expected %0d %0d %0d", cyc, wr_cnt, next_free_id, exp_cyc, exp_wr, exp_nfid); end
  endtask

  task automatic test_fresh_id();
    int cyc; bit to;
    set_row(0, 5, 10, 7, 40); set_row(1, 5, 20, 9, 30); set_row(2, 9, 1, 2, 40);
    load_sb(); model_run(3, 100, 0);
    do_run(3, 100, 0, cyc, to);
    checks++; if (last_id_data !== 100 || last_wr_row !== 1 || bad_cnt !== 0) begin
      errors++; $display("FAIL fresh_write: got id %0d row %0d bad %0d expected 100 1 0", last_id_data, last_wr_row, bad_cnt); end
    checks++; if (sb_id0[1] !== 100 || sb_ptr[1] !== 1'b0 || next_free_id !== 101) begin
      errors++; $display("FAIL fresh_result: got id %0d ptr %0d nfid %0d expected 100 0 101", sb_id0[1], sb_ptr[1], next_free_id); end
    checks++; if (to || cyc !== exp_cyc) begin errors++; $display("FAIL fresh_latency: got %0d expected %0d", cyc, exp_cyc); end
  endtask

  task automatic test_abort();
    int cyc; bit to; bit seen;
    for (int r = 0; r < 4; r++) set_row(r, r + 1, 10, 20, 10);
    load_sb(); model_run(4, 50, 0);
    num_of_rows = (RW+1)'(4); id_base = 8'd50; start_cr = 1'b1;
    @(posedge clk); #1 start_cr = 1'b0;
    @(posedge clk); #1 ready_new_frame = 1'b1;
    @(posedge clk); #1 ready_new_frame = 1'b0;
    checks++; if (row_sel_from_cr !== 0 || write_to_pointer !== 0 || done_cr !== 0) begin
      errors++; $display("FAIL abort_idle: sel=%0d wp=%0d done=%0d expected 0", row_sel_from_cr, write_to_pointer, done_cr); end
    seen = 0;
    for (int k = 0; k < 30; k++) begin @(posedge clk); #1 if (done_cr) seen = 1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_done: got %0d expected 0", seen); end
    do_run(4, 50, 0, cyc, to);
    checks++; if (to || cyc !== exp_cyc || next_free_id !== 50) begin
      errors++; $display("FAIL abort_rerun: cyc=%0d nfid=%0d expected %0d 50", cyc, next_free_id, exp_cyc); end
  endtask

  task automatic test_edges();
    int cyc; bit to;
    for (int n = 0; n < 2; n++) begin
      do_run(n, 20 + n, 0, cyc, to);
      checks++; if (to || cyc !== 2 || next_free_id !== IDW'(20 + n)) begin
        errors++; $display("FAIL edge_rows%0d: cyc=%0d nfid=%0d expected 2 %0d", n, cyc, next_free_id, 20 + n); end
    end
    for (int r = 0; r < 4; r++) set_row(r, r + 1, 10, 20, 10);
    load_sb(); model_run(4, 10, 0);
    do_run(4, 10, 3, cyc, to);
    checks++; if (to || cyc !== exp_cyc || next_free_id !== 10) begin
      errors++; $display("FAIL busy_start: cyc=%0d nfid=%0d expected %0d 10", cyc, next_free_id, exp_cyc); end
  endtask

  task automatic test_watchdog();
    int cyc; bit to;
    set_row(0, 5, 10, 6, 10); set_row(1, 5, 20, 7, 10);
    load_sb(); model_run(2, 90, 1);
    sb_frozen = 1'b1;
    do_run(2, 90, 0, cyc, to);
    sb_frozen = 1'b0;
    checks++; if (to || err_cr !== 1'b1 || cyc !== exp_cyc || next_free_id !== exp_nfid) begin
      errors++; $display("FAIL watchdog: err=%0d cyc=%0d nfid=%0d expected 1 %0d %0d", err_cr, cyc, next_free_id, exp_cyc, exp_nfid); end
    repeat (3) @(posedge clk); #1;
    checks++; if (err_cr !== 1'b1) begin errors++; $display("FAIL err_hold: got %0d expected 1", err_cr); end
    do_run(0, 5, 0, cyc, to);
    checks++; if (err_cr !== 1'b0) begin errors++; $display("FAIL err_clear: got %0d expected 0", err_cr); end
  endtask

  task automatic test_reset_in_write();
    int k;
    set_row(0, 5, 10, 3, 40); set_row(1, 5, 20, 8, 40);
    load_sb();
    num_of_rows = (RW+1)'(2); id_base = 8'd60; start_cr = 1'b1;
    @(posedge clk); #1 start_cr = 1'b0;
    k = 0;
    while (!write_to_pointer && k < 20) begin @(posedge clk); #1 k++; end
    checks++; if (write_to_pointer !== 1'b1) begin errors++; $display("FAIL rst_write_reach: got %0d expected 1", write_to_pointer); end
    #2 reset_N = 1'b0;
    #1;
    checks++; if ({write_to_pointer, data_from_cr_pointer, write_to_id, done_cr} !== 4'b0 || next_free_id !== 0 || row_to_change !== 0) begin
      errors++; $display("FAIL rst_async: strobes=%b nfid=%0d row=%0d expected 0",
        {write_to_pointer, data_from_cr_pointer, write_to_id, done_cr}, next_free_id, row_to_change); end
    @(negedge clk); reset_N = 1'b1;
  endtask

  task automatic test_random();
    int cyc, n, base, bad; bit to;
    for (int it = 0; it < 25; it++) begin
      for (int r = 0; r < MR; r++)
        set_row(r, $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 3));
      n = $urandom_range(0, MR); base = $urandom_range(100, 200);
      load_sb(); model_run(n, IDW'(base), 0);
      do_run(n, base, 0, cyc, to);
      bad = 0;
      for (int r = 0; r < n; r++) begin
        if ((sb_ptr[r] ? sb_id1[r] : sb_id0[r]) !== exp_id[r]) bad++;
        for (int q = 0; q < r; q++)
          if ((sb_ptr[r] ? sb_id1[r] : sb_id0[r]) === (sb_ptr[q] ? sb_id1[q] : sb_id0[q])) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rand_ids it%0d: got %0d bad rows expected 0", it, bad); end
      checks++; if (to || cyc !== exp_cyc || wr_cnt !== exp_wr || bad_cnt !== 0) begin
        errors++; $display("FAIL rand_run it%0d: cyc=%0d wr=%0d bad=%0d expected %0d %0d 0", it, cyc, wr_cnt, bad_cnt, exp_cyc, exp_wr); end
      checks++; if (next_free_id !== exp_nfid || err_cr !== 1'b0) begin
        errors++; $display("FAIL rand_nfid it%0d: got %0d err %0d expected %0d 0", it, next_free_id, err_cr, exp_nfid); end
    end
  endtask

  initial begin
    test_reset();
    test_no_conflict();
    test_simple_conflict();
    test_cascade();
    test_fresh_id();
    test_abort();
    test_edges();
    test_watchdog();
    test_reset_in_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
